// File: rtl/mem_xfer_ctrl_pkg.sv
// Shared state encoding, direction constants and default widths for the
// mem_xfer_ctrl block-transfer initiator.
package mem_xfer_ctrl_pkg;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 4;

  localparam logic DIR_RAM2REG = 1'b0;
  localparam logic DIR_REG2RAM = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    FIN
  } xfer_state_t;

endpackage

// File: rtl/mem_xfer_ctrl_addr_gen.sv
// Source/destination address pair with modulo-2**AW wrap and a remaining-word
// down-counter; one instance serves both sides of a transfer.
module xfer_addr_gen
  import mem_xfer_ctrl_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [AW:0]   len,
  output logic [AW-1:0] src,
  output logic [AW-1:0] dst,
  output logic          last
);

  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  logic [AW:0] cnt;
  logic [AW:0] len_clamped;

  // A store only holds 2**AW words, so longer requests copy each word once.
  assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src <= '0;
      dst <= '0;
      cnt <= '0;
    end else if (load) begin
      src <= src_base;
      dst <= dst_base;
      cnt <= len_clamped;
    end else if (step) begin
      src <= src + AW'(1);
      dst <= dst + AW'(1);
      cnt <= cnt - (AW+1)'(1);
    end
  end

  // Flags the word whose write brings the count to zero.
  assign last = (cnt == (AW+1)'(1));

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Block-transfer initiator copying a run of words between the RAM and the
// register file. Optional XFER_CHECKSUM_EN adds a running XOR of written words.
module mem_xfer_ctrl
  import mem_xfer_ctrl_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          ram_cs,
  output logic          ram_rd,
  output logic          ram_wrt,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          reg_en,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  input  logic [DW-1:0] reg_rdata
`ifdef XFER_CHECKSUM_EN
  ,
  output logic [DW-1:0] chk
`endif
);

  xfer_state_t   state, state_nxt;
  logic          dir_q;
  logic [DW-1:0] data_q;
  logic [1:0]    wait_cnt;
  logic [AW-1:0] src, dst;
  logic          last;
  logic          accept;
  logic          load;

  assign accept = (state == IDLE) && start;
  assign load   = accept && (len != '0);

  xfer_addr_gen #(.AW(AW)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (state == WR),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .src      (src),
    .dst      (dst),
    .last     (last)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q    <= DIR_RAM2REG;
      data_q   <= '0;
      wait_cnt <= '0;
    end else begin
      if (load) dir_q <= dir;
      if (state == RD) wait_cnt <= 2'(READ_LAT - 1);
      else if (state == WAIT && wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
      // Read data is valid only on the last WAIT cycle.
      if (state == WAIT && wait_cnt == 2'd0)
        data_q <= (dir_q == DIR_RAM2REG) ? ram_rdata : reg_rdata;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (len != '0) ? RD : FIN;
      RD:   state_nxt = WAIT;
      WAIT: if (wait_cnt == 2'd0) state_nxt = WR;
      WR:   state_nxt = last ? FIN : RD;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    ram_cs    = 1'b0;
    ram_rd    = 1'b0;
    ram_wrt   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    reg_en    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    case (state)
      RD, WAIT: begin
        busy = 1'b1;
        if (dir_q == DIR_RAM2REG) begin
          ram_addr = src;
          if (state == RD) begin
            ram_cs = 1'b1;
            ram_rd = 1'b1;
          end
        end else begin
          reg_addr = src;
        end
      end
      WR: begin
        busy = 1'b1;
        if (dir_q == DIR_RAM2REG) begin
          reg_en    = 1'b1;
          reg_addr  = dst;
          reg_wdata = data_q;
        end else begin
          ram_cs    = 1'b1;
          ram_wrt   = 1'b1;
          ram_addr  = dst;
          ram_wdata = data_q;
        end
      end
      FIN: done = 1'b1;
      default: ;
    endcase
  end

`ifdef XFER_CHECKSUM_EN
  // Cleared on any accepted start, including len=0, and held after FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               chk <= '0;
    else if (accept)       chk <= '0;
    else if (state == WR)  chk <= chk ^ data_q;
  end
`endif

endmodule
